// File: rtl/axi4_lite_read_slave.sv
// ============================================================================
// axi4_lite_read_slave : AXI4-Lite read responder with window decode,
// alignment check and req/ack backend with timeout.  Rev 1.0
// ============================================================================
`default_nettype none

module axi4_lite_read_slave #(
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned            SIZE_BYTES     = 4096,
    parameter int unsigned            TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,

    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_ack,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_err
);

    localparam int unsigned ALIGN_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]      C_CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0]   C_BASE_EXT   = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0]   C_SIZE_EXT   = (ADDR_WIDTH + 1)'(SIZE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;
    localparam logic [1:0] C_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESP     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Range check in one extra bit so addresses below BASE cannot wrap into the window.
    logic [ADDR_WIDTH:0] w_addr_ext;
    logic [ADDR_WIDTH:0] w_diff;
    logic                w_in_range;
    logic                w_misaligned;
    logic                w_ar_hs;

    assign w_addr_ext   = {1'b0, S_AXI_ARADDR};
    assign w_diff       = w_addr_ext - C_BASE_EXT;
    assign w_in_range   = (w_addr_ext >= C_BASE_EXT) && (w_diff < C_SIZE_EXT);
    assign w_misaligned = |(S_AXI_ARADDR & C_ALIGN_MASK);
    assign w_ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rresp_q <= C_RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;

        case (state_q)
            ST_IDLE: begin
                if (w_ar_hs) begin
                    addr_d = w_diff[ADDR_WIDTH-1:0];
                    cnt_d  = '0;
                    if (!w_in_range) begin
                        rdata_d = '0;
                        rresp_d = C_RESP_DECERR;
                        state_d = ST_RESP;
                    end else if (w_misaligned) begin
                        rdata_d = '0;
                        rresp_d = C_RESP_SLVERR;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
            end

            ST_MEM_WAIT: begin
                // An ack in the final wait cycle takes priority over the timeout.
                if (mem_rd_ack) begin
                    rdata_d = mem_rd_data;
                    rresp_d = mem_rd_err ? C_RESP_SLVERR : C_RESP_OKAY;
                    state_d = ST_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    rdata_d = '0;
                    rresp_d = C_RESP_SLVERR;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (S_AXI_RREADY) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign S_AXI_ARREADY = (state_q == ST_IDLE) && !rst;
    assign S_AXI_RVALID  = (state_q == ST_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign mem_rd_req    = (state_q == ST_MEM_WAIT);
    assign mem_rd_addr   = addr_q;

endmodule

`default_nettype wire

// File: doc/axi4_lite_read_slave.md
# axi4_lite_read_slave

AXI4-Lite read-channel responder that accepts read addresses from an AXI4-Lite read master and returns data fetched from a simple request/acknowledge backend (RAM, register bank or peripheral). It sits between the SoC interconnect and a memory-mapped target. It performs address-range decode, alignment checking and backend timeout detection, and returns OKAY, SLVERR or DECERR on the R channel.

## Interface
- ADDR_WIDTH, 32, address width in bits
- DATA_WIDTH, 32, data width in bits (32 or 64)
- BASE_ADDR, 0, first byte address decoded by this slave
- SIZE_BYTES, 4096, size of the decoded window in bytes
- TIMEOUT_CYCLES, 16, maximum number of backend wait cycles before an SLVERR (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  slave accepts address
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- S_AXI_RVALID  out  1  read data/response valid
- S_AXI_RREADY  in  1  master accepts data
- mem_rd_req  out  1  backend read request, held until ack or timeout
- mem_rd_addr  out  ADDR_WIDTH  byte offset (ARADDR − BASE_ADDR), stable while mem_rd_req=1
- mem_rd_ack  in  1  backend data valid this cycle
- mem_rd_data  in  DATA_WIDTH  backend data, sampled when mem_rd_ack=1
- mem_rd_err  in  1  backend error, sampled with mem_rd_ack

## Operation
- FSM states: ST_IDLE, ST_MEM_WAIT, ST_RESP. Reset state is ST_IDLE.
- ST_IDLE: S_AXI_ARREADY=1, except while rst is asserted, when it is 0. On ARVALID&ARREADY, latch ARADDR and decode:
  - out of range (ARADDR < BASE_ADDR, or ARADDR−BASE_ADDR ≥ SIZE_BYTES; compare in ADDR_WIDTH+1 bits, no wrap): RDATA←0, RRESP←11, go to ST_RESP. No backend access.
  - in range but misaligned (low log2(DATA_WIDTH/8) bits ≠ 0): RDATA←0, RRESP←10, go to ST_RESP. No backend access.
  - otherwise: clear the timeout counter and go to ST_MEM_WAIT.
- ST_MEM_WAIT: mem_rd_req=1, mem_rd_addr=latched offset, ARREADY=0.
  - mem_rd_ack=1: RDATA←mem_rd_data, RRESP←(mem_rd_err ? 10 : 00), go to ST_RESP.
  - no ack: the counter increments. When the counter reaches TIMEOUT_CYCLES−1 without an ack, set RDATA←0, RRESP←10 and go to ST_RESP. mem_rd_req is therefore high for at most TIMEOUT_CYCLES cycles.
  - If ack and the timeout occur in the same cycle, the ack wins.
- ST_RESP: RVALID=1. RDATA and RRESP are registered and held stable until RREADY. On RVALID&RREADY, go to ST_IDLE.
- mem_rd_ack outside ST_MEM_WAIT is ignored.
- One outstanding transaction at a time. ARREADY is never high outside ST_IDLE.
- Reset mid-transaction, any state: immediate return to ST_IDLE. RVALID and mem_rd_req drop asynchronously, and the pending transaction is discarded with no response.

## Timing
- Reset values: ARREADY=0 while rst is asserted (1 from the first cycle after release), RVALID=0, RDATA=0, RRESP=00, mem_rd_req=0, mem_rd_addr=0.
- AR handshake at edge N:
  - error path: RVALID=1 from cycle N+1.
  - backend path: mem_rd_req=1 from cycle N+1. Ack in cycle N+1+k gives RVALID=1 in cycle N+2+k.
- Timeout path: mem_rd_req is high for cycles N+1 … N+TIMEOUT_CYCLES, and RVALID rises in cycle N+TIMEOUT_CYCLES+1.
- R handshake at edge M: RVALID=0 and ARREADY=1 in cycle M+1. The next AR handshake occurs no earlier than edge M+1.
- Minimum transaction cycle: 2 cycles for the error path, 3 cycles for a backend path with ack in the first wait cycle, with RREADY held high.
- All outputs except ARREADY (rst-gated) are driven from state or registers. There is no combinational path from any input to any output.

## Test plan
- AR 0x0000_0010, ack in first MEM_WAIT cycle with data 0xCAFE_F00D, RREADY=1 → mem_rd_addr=0x10, RVALID one cycle later with RDATA=0xCAFE_F00D, RRESP=00.
- BASE_ADDR=0x1000, AR 0x1008, ack after 3 wait cycles, RREADY low for 2 cycles → RDATA/RRESP stable for 3 cycles, mem_rd_addr=0x8, ARREADY=0 until the cycle after the R handshake.
- AR 0x0000_2000 (SIZE 4096) and AR 0xFFFF_FFFC with BASE 0x1000 → RRESP=11, RDATA=0, mem_rd_req never asserted.
- AR 0x0000_0006 → RRESP=10, RDATA=0, no backend request. Separately, ack with mem_rd_err=1 and data 0x1234 → RRESP=10, RDATA=0x1234.
- TIMEOUT_CYCLES=16, backend never acks → mem_rd_req high exactly 16 cycles, then RRESP=10, RDATA=0. Separately, ack in the 16th wait cycle → RRESP=00 (ack wins).
- Assert rst during ST_MEM_WAIT and again during ST_RESP with RREADY low → RVALID and mem_rd_req drop immediately, ARREADY=1 after release, and the next read completes normally with no stale response.
